ascon_seq_fsm: RTL

ASCON_SEQ_FSM -- requirements
Module: ascon_seq_fsm

---
 rtl/ascon_seq_fsm_if.sv | 21 ++
 rtl/ascon_seq_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ascon_seq_fsm_if.sv
// Host handshake of the Ascon round sequencer: operation start/mode, data-block offer, status.
interface ascon_seq_fsm_if;
  logic i_start;
  logic i_decrypt;
  logic i_ad_present;
  logic i_data_valid;
  logic i_last_block;
  logic o_ready;
  logic o_busy;
  logic o_done;

  modport master (
    output i_start, i_decrypt, i_ad_present, i_data_valid, i_last_block,
    input  o_ready, o_busy, o_done
  );

  modport slave (
    input  i_start, i_decrypt, i_ad_present, i_data_valid, i_last_block,
    output o_ready, o_busy, o_done
  );
endinterface

// File: rtl/ascon_seq_fsm.sv
// Ascon AEAD round sequencer: Moore FSM driving the permutation datapath enables.
// Optional abort input/pulse output is built when ASCON_SEQ_FSM_ABORT_EN is defined.
module ascon_seq_fsm #(
  parameter int unsigned NB_ROUNDS_A = 12,
  parameter int unsigned NB_ROUNDS_B = 6,
  parameter int unsigned BLOCK_CNT_W = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   i_sys_enable,
`ifdef ASCON_SEQ_FSM_ABORT_EN
  input  logic                   i_abort,
  output logic                   o_aborted,
`endif
  ascon_seq_fsm_if.slave         bus,
  output logic                   o_decrypt,
  output logic [3:0]             o_round,
  output logic [BLOCK_CNT_W-1:0] o_block_count,
  output logic                   o_mux_select,
  output logic                   o_enable_state_reg,
  output logic                   o_enable_xor_data_begin,
  output logic                   o_enable_xor_key_begin,
  output logic                   o_enable_xor_key_end,
  output logic                   o_enable_xor_lsb_end,
  output logic                   o_enable_cipher_reg,
  output logic                   o_valid_cipher,
  output logic                   o_enable_tag_reg
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FIN, S_DONE
  } state_t;

  localparam logic [3:0]             LP_A_LAST  = 4'(NB_ROUNDS_A - 1);
  localparam logic [3:0]             LP_B_LAST  = 4'(NB_ROUNDS_B - 1);
  localparam logic [BLOCK_CNT_W-1:0] LP_CNT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_round;
  logic [3:0]             w_round_nxt;
  logic [BLOCK_CNT_W-1:0] r_block_count;
  logic [BLOCK_CNT_W-1:0] w_block_count_nxt;
  logic                   r_decrypt;
  logic                   r_ad_present;
  logic                   r_last;
  logic                   w_abort;
  logic                   w_abort_hit;
  logic                   w_in_round;
  logic                   w_long_round;
  logic                   w_round_last;
  logic                   w_round0;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_start_op;

`ifdef ASCON_SEQ_FSM_ABORT_EN
  logic r_aborted;
  assign w_abort   = i_abort;
  assign o_aborted = r_aborted;
`else
  assign w_abort   = 1'b0;
`endif

  assign w_in_round   = (r_state == S_INIT) || (r_state == S_AD) ||
                        (r_state == S_PT)   || (r_state == S_FIN);
  assign w_long_round = (r_state == S_INIT) || (r_state == S_FIN);
  assign w_round_last = (r_round == (w_long_round ? LP_A_LAST : LP_B_LAST));
  assign w_round0     = (r_round == 4'd0);
  assign w_ready      = (r_state == S_WAIT_AD) || (r_state == S_WAIT_PT);
  assign w_accept     = w_ready && bus.i_data_valid;
  assign w_start_op   = (r_state == S_IDLE) && bus.i_start && i_sys_enable;
  assign w_abort_hit  = w_abort && (r_state != S_IDLE) && i_sys_enable;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_start)      w_state_nxt = S_INIT;
      S_INIT:    if (w_round_last)     w_state_nxt = r_ad_present ? S_WAIT_AD : S_WAIT_PT;
      S_WAIT_AD: if (bus.i_data_valid) w_state_nxt = S_AD;
      S_AD:      if (w_round_last)     w_state_nxt = r_last ? S_WAIT_PT : S_WAIT_AD;
      S_WAIT_PT: if (bus.i_data_valid) w_state_nxt = bus.i_last_block ? S_FIN : S_PT;
      S_PT:      if (w_round_last)     w_state_nxt = S_WAIT_PT;
      S_FIN:     if (w_round_last)     w_state_nxt = S_DONE;
      S_DONE:                          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
    // Abort, then system disable, override every ordinary transition.
    if (w_abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
    if (!i_sys_enable)                  w_state_nxt = S_IDLE;
  end

  // Round states never re-enter themselves directly, so staying put means "not last round".
  assign w_round_nxt = (w_in_round && (w_state_nxt == r_state)) ? r_round + 4'd1 : 4'd0;

  always_comb begin
    w_block_count_nxt = r_block_count;
    if (!i_sys_enable || w_abort_hit || w_start_op)
      w_block_count_nxt = '0;
    else if ((r_state == S_WAIT_PT) && w_accept && (r_block_count != LP_CNT_MAX))
      w_block_count_nxt = r_block_count + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_round       <= 4'd0;
      r_block_count <= '0;
      r_decrypt     <= 1'b0;
      r_ad_present  <= 1'b0;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_round       <= w_round_nxt;
      r_block_count <= w_block_count_nxt;
      if (w_start_op) begin
        r_decrypt    <= bus.i_decrypt;
        r_ad_present <= bus.i_ad_present;
      end
      if (w_accept)
        r_last <= bus.i_last_block;
    end
  end

`ifdef ASCON_SEQ_FSM_ABORT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_aborted <= 1'b0;
    else          r_aborted <= w_abort_hit;
  end
`endif

  always_comb begin
    o_mux_select            = 1'b1;
    o_enable_state_reg      = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_valid_cipher          = 1'b0;
    o_enable_tag_reg        = 1'b0;
    bus.o_done              = 1'b0;
    case (r_state)
      S_INIT: begin
        o_enable_state_reg   = 1'b1;
        o_mux_select         = !w_round0;
        o_enable_xor_key_end = w_round_last;
        // Without associated data the domain-separation bit lands at the end of INIT.
        o_enable_xor_lsb_end = w_round_last && !r_ad_present;
      end
      S_AD: begin
        o_enable_state_reg      = 1'b1;
        o_enable_xor_data_begin = w_round0;
        o_enable_xor_lsb_end    = w_round_last && r_last;
      end
      S_PT: begin
        o_enable_state_reg      = 1'b1;
        o_enable_xor_data_begin = w_round0;
        o_enable_cipher_reg     = w_round0;
        o_valid_cipher          = w_round0;
      end
      S_FIN: begin
        o_enable_state_reg      = 1'b1;
        o_enable_xor_data_begin = w_round0;
        o_enable_xor_key_begin  = w_round0;
        o_enable_cipher_reg     = w_round0;
        o_valid_cipher          = w_round0;
        o_enable_xor_key_end    = w_round_last;
      end
      S_DONE: begin
        o_enable_tag_reg = 1'b1;
        bus.o_done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_busy     = (r_state != S_IDLE);
  assign o_decrypt      = r_decrypt;
  assign o_round        = r_round;
  assign o_block_count  = r_block_count;

endmodule
